bcd_countdown_timer: RTL

- Multi-digit BCD down-counter: load a preset, count down to zero, pulse `done` once, then stop.
- It is the down-counting, terminal-detecting counterpart to the team's free-running up counters (mod-16 and mod-10).
- Used for timeouts, display countdowns and delay generation.
- Never wraps below zero. Run control is explicit: load, start and pause.

---
 rtl/bcd_countdown_timer_if.sv | 24 ++
 rtl/bcd_countdown_timer.sv | 118 +++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - control and status bundle for bcd_countdown_timer
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  on;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   cout;
  logic                  busy;
  logic                  zero;
  logic                  done;

  modport master (
    output on, load, load_val, start, pause,
    input  cout, busy, zero, done
  );

  modport slave (
    input  on, load, load_val, start, pause,
    output cout, busy, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD down-counter with load/start/pause and one-shot done
module bcd_countdown_timer #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_countdown_timer_if.slave   bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [W-1:0]    cnt;
  logic [W-1:0]    dec_val;
  logic            busy_r;
  logic            done_r;

  // Out-of-range preset digits clamp to 9 so the count is always valid BCD.
  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign dec_val = bcd_dec(cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      presc  <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (bus.load) begin
      cnt    <= bcd_sat(bus.load_val);
      presc  <= '0;
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            presc <= '0;
            if (cnt != '0) begin
              state  <= RUN;
              busy_r <= 1'b1;
            end else begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.pause) begin
            state <= PAUSED;
          end else if (bus.on) begin
            if (presc == LAST) begin
              presc <= '0;
              cnt   <= dec_val;
              // Terminal decrement: done and zero rise together on this edge.
              if (dec_val == '0) begin
                state  <= DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        PAUSED: begin
          if (!bus.pause && bus.start) state <= RUN;
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cout = cnt;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.zero = (cnt == '0);
endmodule
